// File: rtl/ad5662_spi_writer_if.sv
// Valid/ready word channel feeding the AD5662 serializer.
// master drives the word, slave accepts it.
interface ad5662_spi_writer_if;
  logic [15:0] dat_in;
  logic        dat_valid;
  logic        dat_ready;

  modport master (
    output dat_in,
    output dat_valid,
    input  dat_ready
  );

  modport slave (
    input  dat_in,
    input  dat_valid,
    output dat_ready
  );
endinterface

// File: rtl/ad5662_spi_writer.sv
// AD5662 24-bit SPI frame writer for PLL DAC tuning words.
// One holding register, mid-scale write after reset, optional skip.
module ad5662_spi_writer #(
  parameter int          SCLK_DIV         = 4,
  parameter int          SYNC_HIGH_CYCLES = 8,
  parameter logic [15:0] INIT_VALUE       = 16'd32767,
  parameter bit          SKIP_UNCHANGED   = 1'b1,
  parameter logic [1:0]  PD_MODE          = 2'b00
) (
  input  logic                      clk,
  input  logic                      reset,
  ad5662_spi_writer_if.slave        dat,
  output logic                      busy,
  output logic [15:0]               dac_value,
  output logic                      frame_done,
  output logic                      sclk,
  output logic                      mosi,
  output logic                      sync_n
);

  localparam int HW = $clog2(SCLK_DIV + 1);
  localparam int GW = $clog2(SYNC_HIGH_CYCLES + 1);
  localparam logic [HW-1:0] HLOAD = HW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GLOAD = GW'(SYNC_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic          init_q, init_d;
  logic [15:0]   code_q, code_d;
  logic [4:0]    bit_q, bit_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          sync_q, sync_d;
  logic          done_q, done_d;
  logic [15:0]   dacv_q, dacv_d;
  logic          rdy;
  logic          start;

  function automatic logic bit_of(
    input logic [15:0] c,
    input logic [4:0]  b
  );
    logic [23:0] f;
    f = {6'b000000, PD_MODE, c};
    return f[b];
  endfunction

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    code_d  = code_q;
    bit_d   = bit_q;
    half_d  = half_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    sync_d  = sync_q;
    done_d  = 1'b0;
    dacv_d  = dacv_q;
    rdy     = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (init_q) begin
          init_d = 1'b0;
          code_d = INIT_VALUE;
          start  = 1'b1;
        end else begin
          rdy = 1'b1;
          if (dat.dat_valid) begin
            // a word equal to what the DAC holds is consumed silently
            if (!(SKIP_UNCHANGED && dat.dat_in == dacv_q)) begin
              code_d = dat.dat_in;
              start  = 1'b1;
            end
          end
        end
        if (start) begin
          state_d = SHIFT_HI;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          bit_d   = 5'd23;
          mosi_d  = bit_of(code_d, 5'd23);
          half_d  = HLOAD;
        end
      end

      SHIFT_HI: begin
        if (half_q == '0) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          half_d  = HLOAD;
        end else begin
          half_d = half_q - HW'(1);
        end
      end

      SHIFT_LO: begin
        if (half_q == '0) begin
          sclk_d = 1'b1;
          half_d = HLOAD;
          if (bit_q == 5'd0) begin
            state_d = GAP;
            sync_d  = 1'b1;
            mosi_d  = 1'b0;
            dacv_d  = code_q;
            done_d  = 1'b1;
            gap_d   = GLOAD;
          end else begin
            state_d = SHIFT_HI;
            bit_d   = bit_q - 5'd1;
            mosi_d  = bit_of(code_q, bit_q - 5'd1);
          end
        end else begin
          half_d = half_q - HW'(1);
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // reset mid-frame raises sync_n early so the DAC drops the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      init_q  <= 1'b1;
      code_q  <= '0;
      bit_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      sync_q  <= 1'b1;
      done_q  <= 1'b0;
      dacv_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      code_q  <= code_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      dacv_q  <= dacv_d;
    end
  end

  assign dat.dat_ready = rdy;
  assign busy          = (state_q != IDLE);
  assign dac_value     = dacv_q;
  assign frame_done    = done_q;
  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign sync_n        = sync_q;

endmodule

// File: tb/tb_ad5662_spi_writer.sv
// Scoreboard bench: default writer plus a fast PD=11, no-skip writer.
// Frames are reassembled from mosi at falling sclk and popped on frame_done.
module tb_ad5662_spi_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ad5662_spi_writer_if ifa();
  ad5662_spi_writer_if ifb();

  logic        a_busy, a_fd, a_sclk, a_mosi, a_sync;
  logic [15:0] a_dac;
  logic        b_busy, b_fd, b_sclk, b_mosi, b_sync;
  logic [15:0] b_dac;

  ad5662_spi_writer u_a (
    .clk        (clk),
    .reset      (reset),
    .dat        (ifa),
    .busy       (a_busy),
    .dac_value  (a_dac),
    .frame_done (a_fd),
    .sclk       (a_sclk),
    .mosi       (a_mosi),
    .sync_n     (a_sync)
  );

  ad5662_spi_writer #(
    .SCLK_DIV         (1),
    .SYNC_HIGH_CYCLES (1),
    .INIT_VALUE       (16'd32767),
    .SKIP_UNCHANGED   (1'b0),
    .PD_MODE          (2'b11)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .dat        (ifb),
    .busy       (b_busy),
    .dac_value  (b_dac),
    .frame_done (b_fd),
    .sclk       (b_sclk),
    .mosi       (b_mosi),
    .sync_n     (b_sync)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [23:0] m_sh[2];
  int          m_edges[2];
  int          m_low[2];
  int          m_done[2];
  logic        m_ps[2];

  function automatic int low_exp(input int id);
    return (id == 0) ? 192 : 48;
  endfunction

  function automatic logic [1:0] pd(input int id);
    return (id == 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic mon(
    input int          id,
    input logic        sk,
    input logic        mo,
    input logic        sn,
    input logic        fd,
    input logic [15:0] dv
  );
    logic [15:0] e;
    int          qs;
    if (reset) begin
      m_sh[id]    = '0;
      m_edges[id] = 0;
      m_low[id]   = 0;
      m_ps[id]    = 1'b1;
      return;
    end
    if (!sn) m_low[id]++;
    if (m_ps[id] && !sk && !sn) begin
      m_sh[id] = {m_sh[id][22:0], mo};
      m_edges[id]++;
    end
    m_ps[id] = sk;
    if (fd) begin
      m_done[id]++;
      qs = (id == 0) ? exp_a.size() : exp_b.size();
      chk($sformatf("frame_queue%0d", id), qs > 0, 1'b1);
      e = '0;
      if (qs > 0) e = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
      chk($sformatf("frame_bits%0d", id), m_sh[id],
          {6'b000000, pd(id), e});
      chk($sformatf("frame_edges%0d", id), m_edges[id], 24);
      chk($sformatf("frame_low%0d", id), m_low[id], low_exp(id));
      chk($sformatf("frame_dac%0d", id), dv, e);
      m_sh[id]    = '0;
      m_edges[id] = 0;
      m_low[id]   = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_sclk, a_mosi, a_sync, a_fd, a_dac);
    mon(1, b_sclk, b_mosi, b_sync, b_fd, b_dac);
  end

  function automatic logic pick(input int id, input int sel);
    logic [2:0] va;
    logic [2:0] vb;
    va = {a_fd, a_sync, ifa.dat_ready};
    vb = {b_fd, b_sync, ifb.dat_ready};
    return (id == 0) ? va[sel] : vb[sel];
  endfunction

  // sel: 0 dat_ready, 1 sync_n, 2 frame_done
  task automatic wait_for(
    input  int   id,
    input  int   sel,
    input  logic val,
    input  int   budget,
    output int   n
  );
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pick(id, sel) !== val && n < budget);
    if (pick(id, sel) !== val)
      chk($sformatf("wait%0d_%0d", id, sel), pick(id, sel), val);
  endtask

  initial begin
    int   n;
    int   nf;
    int   falls;
    int   done0;
    int   lows;
    logic ps;

    ifa.dat_valid = 1'b0;
    ifa.dat_in    = '0;
    ifb.dat_valid = 1'b0;
    ifb.dat_in    = '0;
    repeat (3) @(negedge clk);

    chk("rst_sync", a_sync, 1'b1);
    chk("rst_sclk", a_sclk, 1'b1);
    chk("rst_mosi", a_mosi, 1'b0);
    chk("rst_ready", ifa.dat_ready, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_fd", a_fd, 1'b0);
    chk("rst_dac", a_dac, 16'd0);
    chk("rst_b_sync", b_sync, 1'b1);
    chk("rst_b_dac", b_dac, 16'd0);

    exp_a.push_back(16'h7FFF);
    exp_b.push_back(16'h7FFF);
    reset = 1'b0;
    wait_for(0, 2, 1'b1, 400, n);
    chk("init_fd_lat", n, 193);
    chk("init_dac", a_dac, 16'h7FFF);

    ifa.dat_in    = 16'hA5C3;
    ifa.dat_valid = 1'b1;
    exp_a.push_back(16'hA5C3);
    wait_for(0, 0, 1'b1, 50, n);
    chk("init_gap", n, 8);
    @(negedge clk);
    chk("a5_accept", a_sync, 1'b0);
    chk("a5_ready", ifa.dat_ready, 1'b0);
    chk("a5_busy", a_busy, 1'b1);
    ifa.dat_valid = 1'b0;
    wait_for(0, 2, 1'b1, 400, n);
    chk("a5_fd_lat", n + 1, 193);
    chk("a5_dac", a_dac, 16'hA5C3);
    wait_for(0, 0, 1'b1, 50, n);
    chk("a5_gap", n, 8);

    done0 = m_done[0];
    ifa.dat_valid = 1'b1;
    @(negedge clk);
    chk("skip_ready", ifa.dat_ready, 1'b1);
    chk("skip_sync", a_sync, 1'b1);
    chk("skip_busy", a_busy, 1'b0);
    ifa.dat_valid = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!a_sync) lows++;
    end
    chk("skip_nolow", lows, 0);
    chk("skip_nodone", m_done[0], done0);

    ifa.dat_in    = 16'h1234;
    ifa.dat_valid = 1'b1;
    exp_a.push_back(16'h1234);
    @(negedge clk);
    chk("w1234_start", a_sync, 1'b0);
    ifa.dat_in = 16'hFFFF;
    exp_a.push_back(16'hFFFF);
    wait_for(0, 2, 1'b1, 400, n);
    chk("w1234_dac", a_dac, 16'h1234);
    wait_for(0, 0, 1'b1, 50, n);
    chk("w1234_gap", n, 8);
    @(negedge clk);
    chk("wffff_start", a_sync, 1'b0);
    ifa.dat_valid = 1'b0;
    wait_for(0, 2, 1'b1, 400, n);
    chk("wffff_dac", a_dac, 16'hFFFF);
    wait_for(0, 0, 1'b1, 50, n);

    ifa.dat_in    = 16'h0001;
    ifa.dat_valid = 1'b1;
    @(negedge clk);
    chk("abort_start", a_sync, 1'b0);
    ifa.dat_valid = 1'b0;
    falls = 0;
    ps    = a_sclk;
    for (int i = 0; i < 400 && falls < 10; i++) begin
      @(negedge clk);
      if (ps && !a_sclk) falls++;
      ps = a_sclk;
    end
    chk("abort_falls", falls, 10);
    done0 = m_done[0];
    reset = 1'b1;
    #1;
    chk("abort_sync", a_sync, 1'b1);
    chk("abort_sclk", a_sclk, 1'b1);
    chk("abort_mosi", a_mosi, 1'b0);
    chk("abort_dac", a_dac, 16'd0);
    chk("abort_busy", a_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_nodone", m_done[0], done0);
    exp_a.push_back(16'h7FFF);
    exp_b.push_back(16'h7FFF);
    reset = 1'b0;
    wait_for(0, 2, 1'b1, 400, n);
    chk("reinit_fd_lat", n, 193);
    chk("reinit_dac", a_dac, 16'h7FFF);
    wait_for(0, 0, 1'b1, 50, n);

    wait_for(1, 0, 1'b1, 10, n);
    ifb.dat_in    = 16'h0000;
    ifb.dat_valid = 1'b1;
    exp_b.push_back(16'h0000);
    @(negedge clk);
    chk("b_start", b_sync, 1'b0);
    chk("b_ready", ifb.dat_ready, 1'b0);
    ifb.dat_valid = 1'b0;
    wait_for(1, 2, 1'b1, 100, nf);
    chk("b_fd_lat", nf + 1, 49);
    wait_for(1, 0, 1'b1, 20, n);
    chk("b_acc_rdy", nf + 1 + n, 50);

    ifb.dat_valid = 1'b1;
    exp_b.push_back(16'h0000);
    @(negedge clk);
    chk("b_noskip", b_sync, 1'b0);
    ifb.dat_valid = 1'b0;
    wait_for(1, 2, 1'b1, 100, n);
    chk("b_dac", b_dac, 16'h0000);
    wait_for(1, 0, 1'b1, 20, n);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ad5662_spi_writer.md
Name: ad5662_spi_writer

Overview:
- Serializes 16-bit VCTCXO tuning words from the reference-PLL loop filter into 24-bit AD5662 SPI frames.
- Sits directly downstream of the PLL DAC-word register (daco) and drives the DAC pins sclk, mosi and sync_n.
- Uses a valid/ready handshake with a single-word holding register, not a FIFO.
- Writes a mid-scale value automatically after reset and can skip writes that would not change the DAC.

Parameters:
- SCLK_DIV, 4: clk cycles per sclk half-period (must be >= 1).
- SYNC_HIGH_CYCLES, 8: minimum clk cycles sync_n stays high between frames (must be >= 1).
- INIT_VALUE, 16'd32767: word written automatically after reset release.
- SKIP_UNCHANGED, 1: if 1, an accepted word equal to dac_value produces no frame.
- PD_MODE, 2'b00: power-down bits PD1:PD0 sent in every frame.

Ports:
- clk  in  1  sample clock (200 MHz).
- reset  in  1  asynchronous, active-high.
- dat_in  in  16  requested DAC code.
- dat_valid  in  1  dat_in valid.
- dat_ready  out  1  block can accept a word.
- busy  out  1  frame or inter-frame gap in progress.
- dac_value  out  16  last code fully shifted to the DAC.
- frame_done  out  1  one-cycle pulse when sync_n rises after a complete frame.
- sclk  out  1  SPI clock to AD5662; idles high.
- mosi  out  1  SPI data, MSB first.
- sync_n  out  1  AD5662 frame sync, active low.

Behaviour:
- Reset (asynchronous, any time):
  - sclk=1, sync_n=1, mosi=0, dat_ready=0, busy=0, frame_done=0, dac_value=16'd0.
  - State goes to IDLE and init_pending is set to 1.
  - A frame in progress is aborted. sync_n rising before the 24th falling sclk edge makes the AD5662 discard the frame, which is intended.
- Frame format: 24 bits, MSB first = 6'b000000, PD_MODE[1:0], code[15:0].
- States: IDLE, SHIFT_HI, SHIFT_LO, GAP.
- IDLE:
  - If init_pending=1: dat_ready=0, load INIT_VALUE, clear init_pending, enter SHIFT_HI. The init frame is never skipped.
  - Otherwise dat_ready=1. An accept (dat_valid && dat_ready on edge T) latches dat_in.
  - If SKIP_UNCHANGED=1 and dat_in==dac_value: stay in IDLE; the word is consumed with no frame and no frame_done pulse.
  - Otherwise enter SHIFT_HI.
  - dat_ready is 0 in every other state. Words presented while dat_ready=0 are not consumed, so the upstream source must hold them.
- SHIFT_HI:
  - At T+1: sync_n=0, sclk=1, mosi=current bit (bit 23 first).
  - Holds SCLK_DIV cycles, then enters SHIFT_LO with sclk=0. This falling edge is where the DAC samples.
- SHIFT_LO:
  - Holds SCLK_DIV cycles with mosi stable.
  - If bits remain: sclk=1, next bit on mosi, back to SHIFT_HI.
  - After bit 0: sclk=1, sync_n=1, dac_value=latched code, frame_done=1 for one cycle, enter GAP.
- GAP: sync_n high for SYNC_HIGH_CYCLES cycles, then IDLE. dat_ready can rise on the next cycle.
- busy=1 from the first cycle of SHIFT_HI through the last GAP cycle.
- Timing (SCLK_DIV=4, SYNC_HIGH_CYCLES=8), accept edge T:
  - sync_n low at T+1.
  - First falling sclk at T+5.
  - 24th falling sclk at T+189.
  - sync_n high and frame_done at T+193.
  - dat_ready high again at T+201.
- Bit counter is 5 bits, counting 23 down to 0. There are exactly 24 falling sclk edges per frame with sync_n low.
- Half-period counter: width ceil(log2(SCLK_DIV+1)), reloaded on every phase change. The gap counter is sized for SYNC_HIGH_CYCLES.
- sclk, mosi and sync_n are driven directly from flops, with no combinational outputs.

Test Plan:
- Release reset, dat_valid=0:
  - one frame of 000000_00_0111111111111111 (INIT_VALUE 32767);
  - sync_n low for 192 cycles with exactly 24 falling sclk edges;
  - dac_value=32767 after frame_done; dat_ready high 8 cycles after sync_n rises.
- After init, present 16'hA5C3 with dat_valid held:
  - accepted on the first dat_ready cycle;
  - mosi sampled at falling sclk gives 24'h00A5C3; frame_done once; dac_value=16'hA5C3.
- With SKIP_UNCHANGED=1, present 16'hA5C3 again:
  - consumed in one cycle; sync_n stays high; no frame_done; dat_ready stays 1.
  - Repeat with SKIP_UNCHANGED=0: a full frame is sent.
- Present 16'h1234, then change dat_in to 16'hFFFF mid-frame while holding valid:
  - the first frame carries 1234 unchanged;
  - FFFF is accepted only after GAP and sent as the second frame.
- Assert reset at the 10th falling sclk of a 16'h0001 frame:
  - same cycle: sync_n=1, sclk=1, mosi=0;
  - dac_value=0, no frame_done;
  - after release, the init frame (32767) is resent.
- PD_MODE=2'b11, SCLK_DIV=1, SYNC_HIGH_CYCLES=1, write 16'h0000:
  - frame bits 000000_11_0...0;
  - sync_n low 48 cycles;
  - accept to dat_ready re-high is 50 cycles.
